tpumac_sat: RTL and testbench
=============================

# tpumac_sat

Parametrised successor of the systolic-array MAC processing element. Each cycle it forwards A/B operands to its east/south neighbours and accumulates signed A×B products into a local accumulator. Compared with the first-generation PE it adds an optional product pipeline register for timing closure, saturating or wrapping accumulation, a sticky overflow flag, a synchronous clear, and an in-flight indicator for drain detection. It drops into the same systolic array tile in place of the single-cycle PE.

## Interface
- BITS_AB, 8: signed operand width for A and B.
- BITS_C, 16: signed accumulator width; must be ≥ 2*BITS_AB (elaboration error otherwise).
- SAT, 1: 1 = clamp accumulation to BITS_C signed range; 0 = two's-complement wrap.
- PIPE, 1: 1 = registered product stage (2-cycle accumulate latency); 0 = combinational product (1-cycle).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  operand enable: forward A/B and launch a MAC.
- WrEn  in  1  load accumulator from Cin.
- clr  in  1  synchronous clear of accumulator, overflow flag and in-flight product.
- Ain  in  BITS_AB  signed A operand.
- Bin  in  BITS_AB  signed B operand.
- Cin  in  BITS_C  signed accumulator preload value.
- Aout  out  BITS_AB  registered A, to east neighbour.
- Bout  out  BITS_AB  registered B, to south neighbour.
- Cout  out  BITS_C  signed accumulator.
- ovf  out  1  sticky overflow flag.
- busy  out  1  product in flight (PIPE=1 only; constant 0 when PIPE=0).

## Operation
- Operand forwarding: on en=1, Aout<=Ain and Bout<=Bin; en=0 holds. clr and WrEn do not affect Aout/Bout.
- Product: P = Ain*Bin, full 2*BITS_AB signed, sign-extended to BITS_C+1 for the add.
- PIPE=1: every edge prod_r<=P and pv<=en&~clr. Accumulate uses prod_r when pv=1. busy=pv.
- PIPE=0: accumulate uses P directly when en=1.
- Accumulate: S = Cout + P, computed at BITS_C+1 bits. S is out of range if outside [-2^(BITS_C-1), 2^(BITS_C-1)-1].
  - Out of range with SAT=1: Cout<=nearest bound.
  - Out of range with SAT=0: Cout<=S[BITS_C-1:0].
  - Either SAT mode: ovf<=1 on any out-of-range accumulate. ovf holds until clr or rst.
- Accumulator update priority, highest first:
  1. rst: Cout, Aout, Bout, ovf, pv all <=0.
  2. clr: Cout<=0, ovf<=0, pv<=0. Any in-flight product is discarded.
  3. WrEn: Cout<=Cin, ovf unchanged. A product completing in the same cycle is dropped, not added.
  4. Accumulate, when a product completes.
  5. Otherwise hold.
- en asserted together with WrEn: the operands still launch. With PIPE=1 the new product adds onto Cin on the next edge.

## Timing
- Reset values: Aout=0, Bout=0, Cout=0, ovf=0, busy=0. rst mid-accumulation discards everything; there is no partial state.
- Aout/Bout latency: 1 edge after en sampled high.
- Cout latency:
  - PIPE=1: operands sampled at edge k; Cout reflects them after edge k+1.
  - PIPE=0: Cout reflects them after edge k.
- Throughput: one MAC per cycle with en held high. Back-to-back products accumulate with no bubbles.
- WrEn latency: Cout=Cin after 1 edge. clr latency: outputs cleared after 1 edge.
- Drain: after the last en, busy is high for exactly 1 cycle (PIPE=1). The controller reads Cout once busy=0.
- No combinational path from any input to any output.

## Test plan
Defaults BITS_AB=8, BITS_C=16, SAT=1, PIPE=1 unless stated.
- Reset: drive inputs nonzero, rst=1 for 2 cycles -> Aout=Bout=Cout=0, ovf=0, busy=0; release, hold en=0 -> all remain 0.
- Basic MAC: WrEn Cin=100; then en with Ain=3, Bin=-4 at edge k -> Aout=3, Bout=-4 after k, busy=1; Cout=88 after k+1. Follow with en for 4 cycles of (2,5) -> Cout=128, no bubbles.
- Saturation:
  - Load 32767, en (127,127) -> Cout=32767, ovf=1.
  - Load -32768, en (-128,127) -> Cout=-32768, ovf=1.
  - SAT=0, load 32767, en (127,127) -> Cout=-16640, ovf=1.
  - clr -> Cout=0, ovf=0.
- Collisions:
  - en (10,10) at edge k, clr at k+1 -> Cout=0, product discarded.
  - en (10,10) at k, WrEn Cin=5 at k+1 -> Cout=5.
  - WrEn Cin=7 together with en (2,3) -> Cout=7 then 13.
- PIPE=0: Cin=-1 loaded, en (-8,8) -> Cout=-65 after 1 edge, busy stays 0.
- rst mid-stream: en continuous with (1,1), rst at arbitrary cycle -> all outputs 0 next edge; no stale product added after rst release.

Source files
------------

// File: rtl/tpumac_sat.sv
// -----------------------------------------------------------------------------
// tpumac_sat: systolic-array multiply-accumulate processing element.
//
// Each cycle the PE forwards its A/B operands to its east/south neighbours and
// accumulates the signed product A*B into a local accumulator. The product can
// optionally be registered (PIPE=1) for timing closure. Accumulation either
// saturates to the signed accumulator range (SAT=1) or wraps (SAT=0). In both
// modes a sticky overflow flag records any out-of-range accumulate.
//
// Parameters:
//   BITS_AB  signed operand width for A and B
//   BITS_C   signed accumulator width, must be >= 2*BITS_AB
//   SAT      1 = clamp on overflow, 0 = two's-complement wrap
//   PIPE     1 = registered product (2-cycle latency), 0 = combinational (1-cycle)
//
// Ports:
//   clk   in   clock, all state changes on rising edge
//   rst   in   synchronous active-high reset
//   en    in   forward A/B and launch a MAC
//   WrEn  in   load accumulator from Cin
//   clr   in   clear accumulator, overflow flag and in-flight product
//   Ain   in   signed A operand
//   Bin   in   signed B operand
//   Cin   in   signed accumulator preload value
//   Aout  out  registered A to east neighbour
//   Bout  out  registered B to south neighbour
//   Cout  out  signed accumulator
//   ovf   out  sticky overflow flag
//   busy  out  product in flight (always 0 when PIPE=0)
//
// Handshake: there is no backpressure. en is a one-cycle "valid" for the
// operands on Ain/Bin; the PE is always ready. A controller drains the PE by
// dropping en and waiting for busy=0 before reading Cout.
// -----------------------------------------------------------------------------
module tpumac_sat #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter bit SAT     = 1'b1,
  parameter bit PIPE    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic                      clr,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout,
  output logic                      ovf,
  output logic                      busy
);

  localparam int PW = 2 * BITS_AB;  // full product width
  localparam int SW = BITS_C + 1;   // sum width, one guard bit above the accumulator

  localparam logic signed [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic signed [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

  generate
    if (BITS_C < PW) begin : g_bad_width
      $error("tpumac_sat: BITS_C must be >= 2*BITS_AB");
    end
  endgenerate

  logic signed [BITS_AB-1:0] a_q, a_d;
  logic signed [BITS_AB-1:0] b_q, b_d;
  logic signed [BITS_C-1:0]  c_q, c_d;
  logic                      ovf_q, ovf_d;

  logic signed [PW-1:0] prod_c;
  logic signed [SW-1:0] prod_ext;
  logic signed [SW-1:0] add_val;
  logic                 add_vld;
  logic signed [SW-1:0] sum;
  logic                 out_of_range;

  // Full-precision signed product, sign-extended to the sum width.
  assign prod_c   = Ain * Bin;
  assign prod_ext = {{(SW-PW){prod_c[PW-1]}}, prod_c};

  generate
    if (PIPE) begin : g_pipe
      logic signed [SW-1:0] prod_q;
      logic                 pv_q;

      // The product register loads every edge; pv marks whether it holds a
      // live product. clr kills a product being launched in the same cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          prod_q <= '0;
          pv_q   <= 1'b0;
        end else begin
          prod_q <= prod_ext;
          pv_q   <= en & ~clr;
        end
      end

      assign add_val = prod_q;
      assign add_vld = pv_q;
      assign busy    = pv_q;
    end else begin : g_comb
      assign add_val = prod_ext;
      assign add_vld = en;
      assign busy    = 1'b0;
    end
  endgenerate

  // One guard bit: the sum is out of range when the top two bits disagree.
  assign sum          = {c_q[BITS_C-1], c_q} + add_val;
  assign out_of_range = sum[SW-1] ^ sum[SW-2];

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    ovf_d = ovf_q;

    // Forwarding depends only on en; clr and WrEn leave it alone.
    if (en) begin
      a_d = Ain;
      b_d = Bin;
    end

    // Accumulator priority: clr, then preload (drops a completing product),
    // then accumulate.
    if (clr) begin
      c_d   = '0;
      ovf_d = 1'b0;
    end else if (WrEn) begin
      c_d = Cin;
    end else if (add_vld) begin
      if (out_of_range) begin
        ovf_d = 1'b1;
        if (SAT) begin
          c_d = sum[SW-1] ? C_MIN : C_MAX;
        end else begin
          c_d = sum[BITS_C-1:0];
        end
      end else begin
        c_d = sum[BITS_C-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end

  assign Aout = a_q;
  assign Bout = b_q;
  assign Cout = c_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_tpumac_sat.sv
// -----------------------------------------------------------------------------
// tb_tpumac_sat: directed bench for tpumac_sat.
// Three instances share one set of inputs:
//   u_p : SAT=1, PIPE=1 (default configuration)
//   u_w : SAT=0, PIPE=1 (wrapping accumulation)
//   u_c : SAT=1, PIPE=0 (combinational product)
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_tpumac_sat;

  logic clk = 1'b0;
  logic rst, en, WrEn, clr;
  logic signed [7:0]  Ain, Bin;
  logic signed [15:0] Cin;

  logic signed [7:0]  aout_p, bout_p, aout_w, bout_w, aout_c, bout_c;
  logic signed [15:0] cout_p, cout_w, cout_c;
  logic ovf_p, ovf_w, ovf_c, busy_p, busy_w, busy_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tpumac_sat #(.BITS_AB(8), .BITS_C(16), .SAT(1'b1), .PIPE(1'b1)) u_p (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .clr(clr),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(aout_p), .Bout(bout_p), .Cout(cout_p), .ovf(ovf_p), .busy(busy_p));

  tpumac_sat #(.BITS_AB(8), .BITS_C(16), .SAT(1'b0), .PIPE(1'b1)) u_w (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .clr(clr),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(aout_w), .Bout(bout_w), .Cout(cout_w), .ovf(ovf_w), .busy(busy_w));

  tpumac_sat #(.BITS_AB(8), .BITS_C(16), .SAT(1'b1), .PIPE(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .clr(clr),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(aout_c), .Bout(bout_c), .Cout(cout_c), .ovf(ovf_c), .busy(busy_c));

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; WrEn = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic do_clr();
    idle(); clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic do_load(input logic signed [15:0] v);
    idle(); Cin = v; WrEn = 1'b1; step(); WrEn = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Ain = 8'sd5; Bin = 8'sd6; Cin = 16'sd9; en = 1'b1; WrEn = 1'b1; clr = 1'b0;
    rst = 1'b1;
    step(); step();
    checks++; if (aout_p !== 8'sd0)  begin errors++; $display("FAIL reset_aout got %0d exp 0", aout_p); end
    checks++; if (bout_p !== 8'sd0)  begin errors++; $display("FAIL reset_bout got %0d exp 0", bout_p); end
    checks++; if (cout_p !== 16'sd0) begin errors++; $display("FAIL reset_cout got %0d exp 0", cout_p); end
    checks++; if (ovf_p !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_p); end
    checks++; if (busy_p !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy_p); end
    checks++; if (cout_c !== 16'sd0) begin errors++; $display("FAIL reset_cout_c got %0d exp 0", cout_c); end
    idle();
    step(); step(); step();
    checks++; if (aout_p !== 8'sd0 || bout_p !== 8'sd0) begin errors++; $display("FAIL reset_hold_ab got %0d,%0d exp 0,0", aout_p, bout_p); end
    checks++; if (cout_p !== 16'sd0 || busy_p !== 1'b0) begin errors++; $display("FAIL reset_hold_c got %0d busy %b exp 0", cout_p, busy_p); end
  endtask

  task automatic test_basic_mac();
    do_load(16'sd100);
    checks++; if (cout_p !== 16'sd100) begin errors++; $display("FAIL load_cout got %0d exp 100", cout_p); end
    en = 1'b1; Ain = 8'sd3; Bin = -8'sd4;
    step();  // edge k
    en = 1'b0;
    checks++; if (aout_p !== 8'sd3)    begin errors++; $display("FAIL mac_aout got %0d exp 3", aout_p); end
    checks++; if (bout_p !== -8'sd4)   begin errors++; $display("FAIL mac_bout got %0d exp -4", bout_p); end
    checks++; if (busy_p !== 1'b1)     begin errors++; $display("FAIL mac_busy got %b exp 1", busy_p); end
    checks++; if (cout_p !== 16'sd100) begin errors++; $display("FAIL mac_cout_k got %0d exp 100", cout_p); end
    checks++; if (cout_c !== 16'sd88)  begin errors++; $display("FAIL mac_cout_c_k got %0d exp 88", cout_c); end
    checks++; if (busy_c !== 1'b0)     begin errors++; $display("FAIL mac_busy_c got %b exp 0", busy_c); end
    step();  // edge k+1
    checks++; if (cout_p !== 16'sd88)  begin errors++; $display("FAIL mac_cout_k1 got %0d exp 88", cout_p); end
    checks++; if (busy_p !== 1'b0)     begin errors++; $display("FAIL mac_drain got %b exp 0", busy_p); end
    // Four back-to-back products of 10.
    en = 1'b1; Ain = 8'sd2; Bin = 8'sd5;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (cout_p !== 16'(88 + 10 * (i - 1))) begin errors++; $display("FAIL b2b_cout_%0d got %0d exp %0d", i, cout_p, 88 + 10 * (i - 1)); end
      checks++; if (cout_c !== 16'(88 + 10 * i))       begin errors++; $display("FAIL b2b_cout_c_%0d got %0d exp %0d", i, cout_c, 88 + 10 * i); end
      checks++; if (busy_p !== 1'b1)                    begin errors++; $display("FAIL b2b_busy_%0d got %b exp 1", i, busy_p); end
    end
    en = 1'b0;
    step();
    checks++; if (cout_p !== 16'sd128) begin errors++; $display("FAIL b2b_final got %0d exp 128", cout_p); end
    checks++; if (busy_p !== 1'b0)     begin errors++; $display("FAIL b2b_drain got %b exp 0", busy_p); end
  endtask

  task automatic test_saturation();
    do_clr();
    // Exactly reaching the positive bound is not an overflow.
    do_load(16'sd16638);
    en = 1'b1; Ain = 8'sd127; Bin = 8'sd127; step(); en = 1'b0; step();
    checks++; if (cout_p !== 16'sd32767 || ovf_p !== 1'b0) begin errors++; $display("FAIL sat_edge got %0d ovf %b exp 32767 ovf 0", cout_p, ovf_p); end
    // Positive overflow.
    do_load(16'sd32767);
    en = 1'b1; Ain = 8'sd127; Bin = 8'sd127; step(); en = 1'b0; step();
    checks++; if (cout_p !== 16'sd32767)  begin errors++; $display("FAIL sat_pos got %0d exp 32767", cout_p); end
    checks++; if (ovf_p !== 1'b1)         begin errors++; $display("FAIL sat_pos_ovf got %b exp 1", ovf_p); end
    checks++; if (cout_w !== -16'sd16640) begin errors++; $display("FAIL wrap_pos got %0d exp -16640", cout_w); end
    checks++; if (ovf_w !== 1'b1)         begin errors++; $display("FAIL wrap_pos_ovf got %b exp 1", ovf_w); end
    // ovf survives a preload.
    do_load(16'sd0);
    checks++; if (ovf_p !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf_p); end
    do_clr();
    checks++; if (cout_p !== 16'sd0 || ovf_p !== 1'b0) begin errors++; $display("FAIL clr got %0d ovf %b exp 0 ovf 0", cout_p, ovf_p); end
    checks++; if (cout_w !== 16'sd0 || ovf_w !== 1'b0) begin errors++; $display("FAIL clr_w got %0d ovf %b exp 0 ovf 0", cout_w, ovf_w); end
    // Negative overflow: -32768 + (-16256).
    do_load(-16'sd32768);
    en = 1'b1; Ain = -8'sd128; Bin = 8'sd127; step(); en = 1'b0; step();
    checks++; if (cout_p !== -16'sd32768) begin errors++; $display("FAIL sat_neg got %0d exp -32768", cout_p); end
    checks++; if (ovf_p !== 1'b1)         begin errors++; $display("FAIL sat_neg_ovf got %b exp 1", ovf_p); end
    checks++; if (cout_w !== 16'sd16512)  begin errors++; $display("FAIL wrap_neg got %0d exp 16512", cout_w); end
    do_clr();
    checks++; if (cout_p !== 16'sd0 || ovf_p !== 1'b0) begin errors++; $display("FAIL clr2 got %0d ovf %b exp 0 ovf 0", cout_p, ovf_p); end
  endtask

  task automatic test_collisions();
    do_clr();
    // clr one edge after launch discards the in-flight product.
    en = 1'b1; Ain = 8'sd10; Bin = 8'sd10; step();
    en = 1'b0; clr = 1'b1; step(); clr = 1'b0;
    checks++; if (cout_p !== 16'sd0 || busy_p !== 1'b0) begin errors++; $display("FAIL col_clr got %0d busy %b exp 0 busy 0", cout_p, busy_p); end
    step();
    checks++; if (cout_p !== 16'sd0) begin errors++; $display("FAIL col_clr_stale got %0d exp 0", cout_p); end
    // Preload wins over a completing product.
    en = 1'b1; Ain = 8'sd10; Bin = 8'sd10; step();
    en = 1'b0; Cin = 16'sd5; WrEn = 1'b1; step(); WrEn = 1'b0;
    checks++; if (cout_p !== 16'sd5) begin errors++; $display("FAIL col_wren got %0d exp 5", cout_p); end
    step();
    checks++; if (cout_p !== 16'sd5) begin errors++; $display("FAIL col_wren_hold got %0d exp 5", cout_p); end
    // Preload and launch together: product adds onto Cin next edge.
    Cin = 16'sd7; WrEn = 1'b1; en = 1'b1; Ain = 8'sd2; Bin = 8'sd3; step();
    WrEn = 1'b0; en = 1'b0;
    checks++; if (cout_p !== 16'sd7 || busy_p !== 1'b1) begin errors++; $display("FAIL col_both_k got %0d busy %b exp 7 busy 1", cout_p, busy_p); end
    checks++; if (aout_p !== 8'sd2 || bout_p !== 8'sd3) begin errors++; $display("FAIL col_both_fwd got %0d,%0d exp 2,3", aout_p, bout_p); end
    step();
    checks++; if (cout_p !== 16'sd13) begin errors++; $display("FAIL col_both_k1 got %0d exp 13", cout_p); end
    // clr does not disturb forwarded operands.
    do_clr();
    checks++; if (aout_p !== 8'sd2 || bout_p !== 8'sd3) begin errors++; $display("FAIL clr_keeps_fwd got %0d,%0d exp 2,3", aout_p, bout_p); end
  endtask

  task automatic test_pipe0();
    do_load(-16'sd1);
    en = 1'b1; Ain = -8'sd8; Bin = 8'sd8; step(); en = 1'b0;
    checks++; if (cout_c !== -16'sd65) begin errors++; $display("FAIL p0_cout got %0d exp -65", cout_c); end
    checks++; if (busy_c !== 1'b0)     begin errors++; $display("FAIL p0_busy got %b exp 0", busy_c); end
    checks++; if (cout_p !== -16'sd1)  begin errors++; $display("FAIL p1_lat got %0d exp -1", cout_p); end
    step();
    checks++; if (cout_c !== -16'sd65 || cout_p !== -16'sd65) begin errors++; $display("FAIL p0p1_final got %0d,%0d exp -65,-65", cout_c, cout_p); end
  endtask

  task automatic test_rst_midstream();
    do_clr();
    en = 1'b1; Ain = 8'sd1; Bin = 8'sd1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (cout_p !== 16'sd4) begin errors++; $display("FAIL stream_pre got %0d exp 4", cout_p); end
    rst = 1'b1; step();
    checks++; if (cout_p !== 16'sd0 || aout_p !== 8'sd0 || bout_p !== 8'sd0) begin errors++; $display("FAIL midrst got c %0d a %0d b %0d exp 0", cout_p, aout_p, bout_p); end
    checks++; if (busy_p !== 1'b0 || ovf_p !== 1'b0 || cout_c !== 16'sd0) begin errors++; $display("FAIL midrst_flags got busy %b ovf %b cc %0d exp 0", busy_p, ovf_p, cout_c); end
    rst = 1'b0; en = 1'b0;
    step();
    checks++; if (cout_p !== 16'sd0) begin errors++; $display("FAIL midrst_stale got %0d exp 0", cout_p); end
    step();
    checks++; if (cout_p !== 16'sd0 || cout_c !== 16'sd0) begin errors++; $display("FAIL midrst_hold got %0d,%0d exp 0,0", cout_p, cout_c); end
  endtask

  initial begin
    idle();
    Ain = '0; Bin = '0; Cin = '0;
    test_reset();
    test_basic_mac();
    test_saturation();
    test_collisions();
    test_pipe0();
    test_rst_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
